// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrates between requesters, runs the granted
// operation through a shared ALU and holds the result in a one-deep output slot.

module alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] y
);

  // Combinational operation decode
  always_comb begin
    y = 8'h00;
    unique case (op)
      4'b0000: y = a;
      4'b0001: y = b;
      4'b0010: y = {a[6:0], 1'b0};
      4'b0011: y = a + b;
      4'b0100: y = a - b;
      4'b0101: y = a & b;
      4'b0110: y = a | b;
      4'b0111: y = a ^ b;
      default: y = 8'h00;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int unsigned RR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic       rsp_id,
  output logic [7:0] done_cnt
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;
  localparam int unsigned CW  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    rsp_y_q, rsp_y_d;
  logic             rsp_id_q, rsp_id_d;
  logic [CW-1:0]    done_cnt_q, done_cnt_d;
  logic             last_grant_q, last_grant_d;

  logic             win_c;
  logic             slot_free_c;
  logic             accept_c;
  logic             drain_c;
  logic [DW-1:0]    alu_a_c, alu_b_c, alu_y_c;
  logic [OPW-1:0]   alu_op_c;

  // Grant winner: depends only on valids and the priority pointer, never on operands
  always_comb begin
    win_c = 1'b0;
    if (RR != 0) begin
      if (req0_valid && req1_valid) win_c = ~last_grant_q;
      else                          win_c = req1_valid;
    end else begin
      win_c = ~req0_valid;
    end
  end

  // Handshake qualification; readys are forced low while reset is asserted
  always_comb begin
    slot_free_c = (state_q == EMPTY) || rsp_ready;
    req0_ready  = !rst && slot_free_c && req0_valid && !win_c;
    req1_ready  = !rst && slot_free_c && req1_valid &&  win_c;
    accept_c    = req0_ready || req1_ready;
    drain_c     = (state_q == FULL) && rsp_ready;
  end

  // Route the granted requester's operands to the shared ALU
  always_comb begin
    alu_a_c  = win_c ? req1_a  : req0_a;
    alu_b_c  = win_c ? req1_b  : req0_b;
    alu_op_c = win_c ? req1_op : req0_op;
  end

  alu u_alu (
    .a  (alu_a_c),
    .b  (alu_b_c),
    .op (alu_op_c),
    .y  (alu_y_c)
  );

  // Slot FSM next state, result capture, pointer and delivery counter
  always_comb begin
    state_d      = state_q;
    rsp_y_d      = rsp_y_q;
    rsp_id_d     = rsp_id_q;
    done_cnt_d   = done_cnt_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      EMPTY:   if (accept_c) state_d = FULL;
      FULL:    if (drain_c && !accept_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (accept_c) begin
      rsp_y_d      = alu_y_c;
      rsp_id_d     = win_c;
      last_grant_d = win_c;
    end

    if (drain_c) done_cnt_d = done_cnt_q + CW'(1);
  end

  // State register; reset discards any pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      rsp_y_q      <= '0;
      rsp_id_q     <= 1'b0;
      done_cnt_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_y_q      <= rsp_y_d;
      rsp_id_q     <= rsp_id_d;
      done_cnt_q   <= done_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority instance
// share the same stimulus.

`timescale 1ns/1ps

module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;

  logic       r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id;
  logic [7:0] r_rsp_y, r_done_cnt;
  logic       f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id;
  logic [7:0] f_rsp_y, f_done_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.RR(1)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(r_rsp_y), .rsp_id(r_rsp_id), .done_cnt(r_done_cnt)
  );

  alu_arbiter #(.RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(f_rsp_y), .rsp_id(f_rsp_id), .done_cnt(f_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req0_op = 4'h0;
    req1_a = 8'h00; req1_b = 8'h00; req1_op = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick(); tick();
    #1;
    n_checks++; if (r_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", r_rsp_valid); end
    n_checks++; if (r_rsp_y !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_y got %h want 00", r_rsp_y); end
    n_checks++; if (r_rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %b want 0", r_rsp_id); end
    n_checks++; if (r_done_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_done_cnt got %h want 00", r_done_cnt); end
    n_checks++; if ({r_req0_ready, r_req1_ready, f_req0_ready, f_req1_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_readys got %b want 0000", {r_req0_ready, r_req1_ready, f_req0_ready, f_req1_ready}); end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h02; req0_op = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if ({r_req0_ready, r_req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready got %b want 10", {r_req0_ready, r_req1_ready}); end
    tick();
    req0_valid = 1'b0;
    n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_y} !== {1'b1, 1'b0, 8'h55}) begin
      n_fail++; $display("FAIL single_rsp got v=%b id=%b y=%h want v=1 id=0 y=55", r_rsp_valid, r_rsp_id, r_rsp_y); end
    n_checks++; if (r_done_cnt !== 8'd0) begin n_fail++; $display("FAIL single_cnt_early got %0d want 0", r_done_cnt); end
    tick();
    n_checks++; if (r_done_cnt !== 8'd1) begin n_fail++; $display("FAIL single_cnt got %0d want 1", r_done_cnt); end
    n_checks++; if (r_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", r_rsp_valid); end
  endtask

  task automatic test_opcodes();
    logic [7:0] a_t [3];
    logic [3:0] op_t [3];
    logic [7:0] y_t [3];
    a_t[0] = 8'h55; op_t[0] = 4'b0001; y_t[0] = 8'h02;
    a_t[1] = 8'h55; op_t[1] = 4'b0010; y_t[1] = 8'hAA;
    a_t[2] = 8'h81; op_t[2] = 4'b0010; y_t[2] = 8'h02;
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1; req1_a = a_t[i]; req1_b = 8'h02; req1_op = op_t[i];
      tick();
      req1_valid = 1'b0;
      n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_y} !== {1'b1, 1'b1, y_t[i]}) begin
        n_fail++; $display("FAIL opcode_%0d got v=%b id=%b y=%h want v=1 id=1 y=%h", i, r_rsp_valid, r_rsp_id, r_rsp_y, y_t[i]); end
      tick();
    end
    n_checks++; if (r_done_cnt !== 8'd4) begin n_fail++; $display("FAIL opcode_cnt got %0d want 4", r_done_cnt); end
  endtask

  task automatic test_tie();
    logic exp_id;
    req0_valid = 1'b1; req0_a = 8'h10; req0_op = 4'b0000;
    req1_valid = 1'b1; req1_a = 8'h20; req1_op = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      #1;
      n_checks++; if ({r_req0_ready, r_req1_ready} !== {~exp_id, exp_id}) begin
        n_fail++; $display("FAIL tie_ready_%0d got %b want %b", i, {r_req0_ready, r_req1_ready}, {~exp_id, exp_id}); end
      tick();
      n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_y} !== {1'b1, exp_id, (exp_id ? 8'h20 : 8'h10)}) begin
        n_fail++; $display("FAIL tie_rsp_%0d got v=%b id=%b y=%h want id=%b", i, r_rsp_valid, r_rsp_id, r_rsp_y, exp_id); end
    end
    idle_inputs();
    tick();
    n_checks++; if (r_done_cnt !== 8'd8) begin n_fail++; $display("FAIL tie_cnt got %0d want 8", r_done_cnt); end
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_a = 8'h55; req0_op = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h33; req1_op = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({r_req0_ready, r_req1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready_%0d got %b want 00", i, {r_req0_ready, r_req1_ready}); end
      n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_y} !== {1'b1, 1'b0, 8'hAA}) begin
        n_fail++; $display("FAIL bp_hold_%0d got v=%b id=%b y=%h want v=1 id=0 y=aa", i, r_rsp_valid, r_rsp_id, r_rsp_y); end
      tick();
    end
    n_checks++; if (r_done_cnt !== 8'd8) begin n_fail++; $display("FAIL bp_cnt_stall got %0d want 8", r_done_cnt); end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (r_req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", r_req1_ready); end
    tick();
    req1_valid = 1'b0;
    n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_y, r_done_cnt} !== {1'b1, 1'b1, 8'h33, 8'd9}) begin
      n_fail++; $display("FAIL bp_swap got v=%b id=%b y=%h cnt=%0d want v=1 id=1 y=33 cnt=9", r_rsp_valid, r_rsp_id, r_rsp_y, r_done_cnt); end
    tick();
    n_checks++; if ({r_rsp_valid, r_done_cnt} !== {1'b0, 8'd10}) begin
      n_fail++; $display("FAIL bp_final got v=%b cnt=%0d want v=0 cnt=10", r_rsp_valid, r_done_cnt); end
  endtask

  task automatic test_reset_full();
    req0_valid = 1'b1; req0_a = 8'h77; req0_op = 4'b0000;
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    n_checks++; if ({r_rsp_valid, r_rsp_y} !== {1'b1, 8'h77}) begin n_fail++; $display("FAIL rf_load got v=%b y=%h want v=1 y=77", r_rsp_valid, r_rsp_y); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    n_checks++; if ({r_rsp_valid, r_done_cnt} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL rf_clear got v=%b cnt=%0d want v=0 cnt=0", r_rsp_valid, r_done_cnt); end
    tick(); tick();
    n_checks++; if ({r_rsp_valid, r_done_cnt} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL rf_discard got v=%b cnt=%0d want v=0 cnt=0", r_rsp_valid, r_done_cnt); end
  endtask

  task automatic test_wrap();
    req0_valid = 1'b1; req0_a = 8'h01; req0_op = 4'b0000;
    req1_valid = 1'b1; req1_a = 8'h02; req1_op = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) tick();
    n_checks++; if (r_done_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", r_done_cnt); end
    idle_inputs();
    tick();
    n_checks++; if ({r_rsp_valid, r_done_cnt} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL wrap_0 got v=%b cnt=%0d want v=0 cnt=0", r_rsp_valid, r_done_cnt); end
  endtask

  task automatic test_fixed_priority();
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h10; req0_op = 4'b0000;
    req1_valid = 1'b1; req1_a = 8'h20; req1_op = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({f_req0_ready, f_req1_ready} !== 2'b10) begin n_fail++; $display("FAIL fp_ready_%0d got %b want 10", i, {f_req0_ready, f_req1_ready}); end
      tick();
      n_checks++; if ({f_rsp_valid, f_rsp_id, f_rsp_y} !== {1'b1, 1'b0, 8'h10}) begin
        n_fail++; $display("FAIL fp_rsp_%0d got v=%b id=%b y=%h want v=1 id=0 y=10", i, f_rsp_valid, f_rsp_id, f_rsp_y); end
    end
    req0_valid = 1'b0;
    #1;
    n_checks++; if ({f_req0_ready, f_req1_ready} !== 2'b01) begin n_fail++; $display("FAIL fp_req1_ready got %b want 01", {f_req0_ready, f_req1_ready}); end
    tick();
    n_checks++; if ({f_rsp_valid, f_rsp_id, f_rsp_y} !== {1'b1, 1'b1, 8'h20}) begin
      n_fail++; $display("FAIL fp_req1_rsp got v=%b id=%b y=%h want v=1 id=1 y=20", f_rsp_valid, f_rsp_id, f_rsp_y); end
    idle_inputs();
    tick();
    n_checks++; if (f_done_cnt !== 8'd4) begin n_fail++; $display("FAIL fp_cnt got %0d want 4", f_done_cnt); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    rsp_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_opcodes();
    test_tie();
    test_backpressure();
    test_reset_full();
    test_wrap();
    test_fixed_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001 Parameter RR, default 1: 1 = round-robin grant, 0 = fixed priority (requester 0 always wins).
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 req0_valid  input  1  requester 0 presents an operation.
- REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when valid && ready.
- REQ-006 req0_a, req0_b  input  8 each  requester 0 operands.
- REQ-007 req0_op  input  4  requester 0 ALU opcode, passed unchanged to alu.
- REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: same widths and meaning as REQ-004..007, for requester 1.
- REQ-009 rsp_valid  output  1  result register holds an undelivered result.
- REQ-010 rsp_ready  input  1  consumer accepts result when rsp_valid && rsp_ready.
- REQ-011 rsp_y  output  8  registered ALU result.
- REQ-012 rsp_id  output  1  requester index that issued rsp_y.
- REQ-013 done_cnt  output  8  count of delivered responses, wraps 255 -> 0.

Function
- REQ-014 Block SHALL instantiate one alu (ports a, b, op, y) and drive its a/b/op from the granted requester only.
- REQ-015 alu opcodes used by this block's tests: 0000 y=a, 0001 y=b, 0010 y=a<<1 (bit 7 dropped); other opcodes passed through unchecked.
- REQ-016 Output slot "free" SHALL mean !rsp_valid || rsp_ready.
- REQ-017 At most one reqN_ready SHALL be high per cycle; reqN_ready high only when slot free and reqN_valid high and N is the grant winner.
- REQ-018 reqN_ready SHALL be combinational from valids, slot-free and priority pointer; no combinational path from reqN_a/b/op to any ready.
- REQ-019 Grant, RR=1: one valid -> that one; both valid -> requester != last_grant; last_grant updates only on an accepted transfer.
- REQ-020 Grant, RR=0: requester 0 whenever req0_valid, else requester 1.
- REQ-021 Latency: operation accepted in cycle N SHALL appear on rsp_y/rsp_id with rsp_valid=1 from cycle N+1.
- REQ-022 rsp_y, rsp_id SHALL hold stable while rsp_valid && !rsp_ready.
- REQ-023 Simultaneous drain and accept (rsp_valid && rsp_ready && new accept) SHALL load the new result with no bubble; rsp_valid stays 1.
- REQ-024 Drain with no accept SHALL clear rsp_valid next cycle.
- REQ-025 FSM: EMPTY (rsp_valid=0) -> FULL on accept; FULL -> EMPTY on drain without accept; FULL -> FULL on stall or drain+accept.
- REQ-026 done_cnt SHALL increment by 1 on each cycle with rsp_valid && rsp_ready, wrapping mod 256.
- REQ-027 Requester with valid held high and not granted SHALL NOT lose its request; block never drops or duplicates an operation.
- REQ-028 Full throughput: with rsp_ready tied 1 and both requesters valid, one accept every cycle, alternating 0,1,0,1 under RR=1.

Reset
- REQ-029 On rst=1 at a clock edge: rsp_valid=0, rsp_y=0, rsp_id=0, done_cnt=0, last_grant=1 (requester 0 wins first tie), state EMPTY.
- REQ-030 While rst=1, req0_ready=req1_ready=0 and no operation is accepted.
- REQ-031 Reset asserted while FULL SHALL discard the pending result; it is never delivered.

Verification
- REQ-032 Single op: req0 a=0x55 b=0x02 op=0000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_y=0x55, rsp_id=0, done_cnt becomes 1 one cycle later.
- REQ-033 Opcodes: req1 a=0x55 b=0x02 op=0001 -> rsp_y=0x02, rsp_id=1; op=0010 -> rsp_y=0xAA; a=0x81 op=0010 -> rsp_y=0x02.
- REQ-034 Tie, RR=1: both valid every cycle, rsp_ready=1, 4 cycles -> rsp_id sequence 0,1,0,1, exactly one ready per cycle.
- REQ-035 Back-pressure: rsp_ready=0 for 3 cycles with result 0xAA pending -> rsp_y holds 0xAA, both readys 0; rsp_ready=1 -> delivered once, next op loaded same cycle.
- REQ-036 Fixed priority, RR=0: both valid 3 cycles -> rsp_id 0,0,0; req1 granted only after req0_valid drops.
- REQ-037 Reset while FULL: rst=1 one cycle with rsp_valid=1 -> rsp_valid=0, done_cnt=0, pending result never seen; 256 deliveries -> done_cnt wraps to 0.
